// File: rtl/anita4_scaler_accumulator.sv
// anita4_scaler_accumulator: 32-channel gated rising-edge rate counter with atomic latch and registered readout.
// Define SCALER_EXT_GATE_EN to latch on gate_i rising edges instead of the internal PERIOD_CYCLES timer.

module anita4_scaler_chan #(
    parameter int COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_scal,
    input  logic               i_latch,
    output logic [COUNT_W-1:0] o_hold,
    output logic               o_sat
);
    localparam logic [COUNT_W-1:0] MAX = '1;

    logic               r_s1, r_s2, r_sat;
    logic [COUNT_W-1:0] r_cnt, r_hold;
    logic               w_inc;
    logic [COUNT_W-1:0] w_next;

    assign w_inc  = r_s1 & ~r_s2;
    // Saturating sum; in the latch cycle this includes the edge detected that cycle.
    assign w_next = (w_inc && (r_cnt != MAX)) ? r_cnt + COUNT_W'(1) : r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_hold <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_s1 <= i_scal;
            r_s2 <= r_s1;
            if (i_latch) begin
                r_hold <= w_next;
                r_cnt  <= '0;
                r_sat  <= (w_next == MAX);
            end else begin
                r_cnt  <= w_next;
            end
        end
    end

    assign o_hold = r_hold;
    assign o_sat  = r_sat;
endmodule

module anita4_scaler_accumulator #(
    parameter int          COUNT_W       = 16,
    parameter logic [31:0] PERIOD_CYCLES = 32'd33000000
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [31:0]        scal_i,
    input  logic               gate_i,
    input  logic               rd_i,
    input  logic [4:0]         addr_i,
    output logic [COUNT_W-1:0] data_o,
    output logic               ack_o,
    output logic               new_o,
    input  logic               clr_new_i,
    output logic [31:0]        sat_o
);
    localparam int NUM_CH = 32;

    logic                           w_latch;
    logic [NUM_CH-1:0][COUNT_W-1:0] w_hold;

`ifdef SCALER_EXT_GATE_EN
    logic r_g1, r_g2;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_g1 <= 1'b0;
            r_g2 <= 1'b0;
        end else begin
            r_g1 <= gate_i;
            r_g2 <= r_g1;
        end
    end

    assign w_latch = r_g1 & ~r_g2;
`else
    logic [31:0] r_timer;
    logic        w_unused_gate;

    assign w_unused_gate = gate_i;
    assign w_latch       = (r_timer == PERIOD_CYCLES - 32'd1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     r_timer <= '0;
        else if (w_latch) r_timer <= '0;
        else              r_timer <= r_timer + 32'd1;
    end
`endif

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            anita4_scaler_chan #(.COUNT_W(COUNT_W)) u_ch (
                .i_clk   (clk_i),
                .i_rst_n (rst_n_i),
                .i_scal  (scal_i[k]),
                .i_latch (w_latch),
                .o_hold  (w_hold[k]),
                .o_sat   (sat_o[k])
            );
        end
    endgenerate

    // A read in the latch cycle sees the pre-latch holding value; a latch overrides a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o <= '0;
            ack_o  <= 1'b0;
            new_o  <= 1'b0;
        end else begin
            ack_o <= rd_i;
            if (rd_i)           data_o <= w_hold[addr_i];
            if (w_latch)        new_o  <= 1'b1;
            else if (clr_new_i) new_o  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_anita4_scaler_accumulator.sv
// Directed bench for anita4_scaler_accumulator (COUNT_W=4, PERIOD_CYCLES=100, internal timer).
// n counts rising edges since reset release; the latch lands on n = 100, 200, 300, ...

module tb_anita4_scaler_accumulator;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] scal_i;
    logic        gate_i;
    logic        rd_i;
    logic [4:0]  addr_i;
    logic [3:0]  data_o;
    logic        ack_o;
    logic        new_o;
    logic        clr_new_i;
    logic [31:0] sat_o;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    anita4_scaler_accumulator #(.COUNT_W(4), .PERIOD_CYCLES(32'd100)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .scal_i    (scal_i),
        .gate_i    (gate_i),
        .rd_i      (rd_i),
        .addr_i    (addr_i),
        .data_o    (data_o),
        .ack_o     (ack_o),
        .new_o     (new_o),
        .clr_new_i (clr_new_i),
        .sat_o     (sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        n++;
        #1;
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        rd_i   = 1'b1;
        addr_i = a;
        step();
        rd_i   = 1'b0;
        chk({tag, "_ack"}, {31'd0, ack_o}, 32'd1);
        chk(tag, {28'd0, data_o}, exp);
    endtask

    task automatic pulse(input int ch, input int times);
        for (int i = 0; i < times; i++) begin
            scal_i[ch] = 1'b1;
            step();
            scal_i[ch] = 1'b0;
            step();
        end
    endtask

    initial begin
        rst_n_i = 1'b0; scal_i = '0; gate_i = 1'b0; rd_i = 1'b0; addr_i = '0; clr_new_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_data", {28'd0, data_o}, 32'd0);
        chk("rst_ack",  {31'd0, ack_o},  32'd0);
        chk("rst_new",  {31'd0, new_o},  32'd0);
        chk("rst_sat",  sat_o,           32'd0);
        @(negedge clk_i); rst_n_i = 1'b1; n = 0;

        // Period 1: 7 pulses on ch3, ch12 held high 50 cycles then 5 toggles.
        pulse(3, 7);                                    // n = 14
        scal_i[12] = 1'b1;
        repeat (50) step();                             // n = 64
        for (int i = 0; i < 5; i++) begin
            scal_i[12] = 1'b0; step();
            scal_i[12] = 1'b1; step();
        end                                             // n = 74
        scal_i[12] = 1'b0;
        run_to(99);
        chk("new_before_latch", {31'd0, new_o}, 32'd0);
        step();                                         // n = 100 latch
        chk("new_at_latch", {31'd0, new_o}, 32'd1);
        chk("sat_p1", sat_o, 32'd0);
        rd(5'd3,  32'd7, "rd_ch3");
        rd(5'd4,  32'd0, "rd_ch4");
        rd(5'd12, 32'd6, "rd_ch12_level");              // n = 103
        clr_new_i = 1'b1; step(); clr_new_i = 1'b0;     // n = 104
        chk("new_cleared", {31'd0, new_o}, 32'd0);

        rd_i = 1'b1; addr_i = 5'd3; step();
        chk("b2b_ack1",  {31'd0, ack_o}, 32'd1);
        chk("b2b_data1", {28'd0, data_o}, 32'd7);
        addr_i = 5'd12; step();
        chk("b2b_ack2",  {31'd0, ack_o}, 32'd1);
        chk("b2b_data2", {28'd0, data_o}, 32'd6);
        rd_i = 1'b0; step();                            // n = 107
        chk("idle_ack",       {31'd0, ack_o}, 32'd0);
        chk("idle_data_hold", {28'd0, data_o}, 32'd6);

        // Period 2: 20 toggles on ch0 saturate; latch-boundary edges on ch5/ch6.
        pulse(0, 20);                                   // n = 147
        run_to(198);
        scal_i[5] = 1'b1; step();                       // n = 199
        scal_i[5] = 1'b0; scal_i[6] = 1'b1;
        rd_i = 1'b1; addr_i = 5'd3; clr_new_i = 1'b1;
        step();                                         // n = 200 latch
        scal_i[6] = 1'b0; rd_i = 1'b0; clr_new_i = 1'b0;
        chk("rd_in_latch_ack",  {31'd0, ack_o}, 32'd1);
        chk("rd_in_latch_data", {28'd0, data_o}, 32'd7);
        chk("clr_in_latch_new", {31'd0, new_o}, 32'd1);
        chk("sat_p2", sat_o, 32'h0000_0001);
        rd(5'd0, 32'd15, "rd_sat_ch0");
        rd(5'd5, 32'd1,  "rd_edge_in_latch");
        rd(5'd6, 32'd0,  "rd_edge_after_latch");
        rd(5'd3, 32'd0,  "rd_ch3_p2");                  // n = 204

        // Period 3: ch0 recovers from saturation; ch6 edge carried over.
        pulse(0, 2);                                    // n = 208
        run_to(300);
        chk("sat_p3", sat_o, 32'd0);
        rd(5'd0, 32'd2, "rd_ch0_p3");
        rd(5'd6, 32'd1, "rd_ch6_p3");                   // n = 302

        // Period 4: partial counts on ch21, then asynchronous reset between edges.
        pulse(21, 4);                                   // n = 310
        step(); step();
        chk("pre_rst_new",  {31'd0, new_o}, 32'd1);
        chk("pre_rst_data", {28'd0, data_o}, 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("async_rst_data", {28'd0, data_o}, 32'd0);
        chk("async_rst_ack",  {31'd0, ack_o},  32'd0);
        chk("async_rst_new",  {31'd0, new_o},  32'd0);
        chk("async_rst_sat",  sat_o,           32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_n_i = 1'b1; n = 0;
        run_to(99);
        chk("post_rst_new_pre", {31'd0, new_o}, 32'd0);
        step();
        chk("post_rst_new_latch", {31'd0, new_o}, 32'd1);
        rd(5'd21, 32'd0, "rd_ch21_discarded");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/anita4_scaler_accumulator.md
# anita4_scaler_accumulator

Gated 32-channel rate counter that consumes the per-channel scaler strobes produced by the ANITA4 TURF trigger processor: L0 scalers on bits 0–11, L1 on 12–17, L2 on 18–19, and the registered reference pulse on 21. Each gate period, it counts rising edges per channel, then atomically latches all counts into holding registers. The holding registers are read out through a registered, address-based read port feeding the SURF register/housekeeping path.

## Interface
Parameters:
- `COUNT_W`, 16, per-channel counter and holding-register width.
- `PERIOD_CYCLES`, 33000000, gate length in clk_i cycles (1 s at 33 MHz); legal range 2 to 2^32-1.

Ports:
- `clk_i`  input  1  single clock for the whole block (master clock domain).
- `rst_n_i`  input  1  reset; asynchronous assert, active-low.
- `scal_i`  input  32  scaler strobes/levels, synchronous to clk_i.
- `gate_i`  input  1  external gate strobe; used only with `SCALER_EXT_GATE_EN`.
- `rd_i`  input  1  read request, one-cycle strobe.
- `addr_i`  input  5  channel to read.
- `data_o`  output  COUNT_W  holding-register value for the requested channel.
- `ack_o`  output  1  one-cycle strobe qualifying `data_o`.
- `new_o`  output  1  sticky flag: a new set of counts has been latched since the last clear.
- `clr_new_i`  input  1  clears `new_o`.
- `sat_o`  output  32  per-channel saturation flags for the latched period.

## Operation
- Input stage:
  - Each `scal_i` bit is registered (r1), then delayed again (r2).
  - `inc[k] = r1[k] & ~r2[k]`, i.e. one count per rising edge. A level held high counts once.
- Counters:
  - `cnt[k]` increments on `inc[k]`.
  - It saturates at 2^COUNT_W-1; there is no wrap.
- Period timer:
  - 32-bit timer counts 0 to PERIOD_CYCLES-1, then wraps to 0.
  - The latch cycle is the cycle in which timer = PERIOD_CYCLES-1.
- Latch cycle, all channels in the same cycle:
  - `hold[k] <= sat(cnt[k] + inc[k])`, so an edge detected in the latch cycle belongs to the ending period.
  - `cnt[k] <= 0`.
  - `sat_o[k] <= 1` if the latched value equals all-ones, else 0.
  - `new_o <= 1`.
- `new_o`:
  - Cleared by `clr_new_i`.
  - If `clr_new_i` and a latch occur in the same cycle, the latch wins and `new_o` stays 1.
- Read port:
  - On `rd_i`, `data_o <= hold[addr_i]` and `ack_o <= 1` for one cycle.
  - If `rd_i` coincides with a latch, the read returns the previous period's value.
  - Back-to-back `rd_i` on consecutive cycles is legal and yields an ack on each following cycle.
  - `data_o` holds its last value when `ack_o` is 0.
- Reset: any assertion of `rst_n_i` clears all of the following, mid-period or otherwise. The partial period is discarded.
  - counters, holding registers, timer, r1/r2
  - `data_o`, `ack_o`, `new_o`, `sat_o`, all to 0

## Timing
- Reset values: `data_o` = 0, `ack_o` = 0, `new_o` = 0, `sat_o` = 0.
- Input-to-count latency: an edge on `scal_i` sampled at clock edge n sets r1 at n. `inc` is high during cycle n..n+1, and `cnt` updates at edge n+1.
- First latch after reset release: at the PERIOD_CYCLES-th rising clk_i edge, counting the first edge with `rst_n_i` high as edge 1. Subsequent latches follow every PERIOD_CYCLES edges.
- Read latency: `rd_i` sampled at edge n gives `ack_o` and `data_o` valid from edge n to edge n+1.
- `new_o` rises at the latch edge; `clr_new_i` takes effect at the next edge.

## Configuration
- `SCALER_EXT_GATE_EN` defined:
  - The internal timer is not built and `PERIOD_CYCLES` is ignored.
  - `gate_i` is registered and edge-detected exactly like `scal_i`.
  - The latch cycle is the cycle in which the `gate_i` rising edge is detected. This allows gating on the TURF reference pulse.
  - The first gate edge after reset latches the partial period.
- `SCALER_EXT_GATE_EN` undefined: the internal timer defines the latch cycle and `gate_i` is unused.

## Test plan
- Basic count and read: with PERIOD_CYCLES=100 and no gate macro, pulse `scal_i[3]` for one cycle 7 times within the first period. After the first latch, `new_o`=1. Then `rd_i` with `addr_i`=3 gives `ack_o`=1 one cycle later with `data_o`=7; `addr_i`=4 reads 0.
- Level and edge rule: hold `scal_i[12]` high for 50 cycles, then toggle it 5 times in the same period. The latched value is 6; `sat_o[12]`=0.
- Saturation: with COUNT_W=4, toggle `scal_i[0]` 20 times in one period. Read gives 15, `sat_o[0]`=1. The next period with 2 toggles reads 2 and `sat_o[0]`=0.
- Latch boundaries:
  - An edge detected in the latch cycle counts in the ending period; an edge one cycle later counts in the next.
  - `rd_i` in the latch cycle returns the prior value.
  - `clr_new_i` in the latch cycle leaves `new_o`=1.
- Reset mid-period: after 4 counts on channel 21, assert `rst_n_i` low asynchronously, between clock edges. All outputs go to 0 immediately. After release, the next latch occurs 100 cycles later and reads 0 for channel 21 when no further edges arrive.
- Ext gate (macro defined): drive `gate_i` edges 37 cycles apart with 3 pulses on `scal_i[18]` in between. Each latch reads 3, and `new_o` sets on each gate edge.
